sfp_tx_align_gen: RTL and testbench
===================================

Name: sfp_tx_align_gen

Overview:
- Transmit-side counterpart of the receive word aligner in the SFP 8b/10b link.
- Sits between sfp_encoder's 32-bit word stream and the GT TX data/charisk inputs, in the TX user clock domain.
- After reset it emits a training burst of comma alignment words so the far-end aligner can lock.
- It then forwards upstream words and periodically inserts alignment bursts; it emits UNUSE idle words when upstream has nothing to send.

Parameters:
- TRAIN_LEN, 64, number of alignment words emitted after reset before any data slot (>=1).
- ALIGN_PERIOD, 256, one alignment burst is inserted after every ALIGN_PERIOD-1 data/idle slots (>=2).
- ALIGN_BURST, 4, number of consecutive alignment words per inserted burst (>=1).
- ALIGN_WORD, 32'h55a100bc, alignment word; K28.5 is in byte 0.
- IDLE_WORD, 32'h55a109bc, filler word used when s_valid=0; equals the link UNUSE_DATA.

Ports:
- clk, input, 1, TX user clock. This is the only clock.
- rst, input, 1, asynchronous active-high reset.
- s_data, input, 32, upstream word.
- s_charisk, input, 4, upstream K-flags, one per byte.
- s_valid, input, 1, upstream word present.
- s_ready, output, 1, block accepts s_data this cycle.
- gt_txdata, output, 32, registered word to the GT.
- gt_txcharisk, output, 4, registered K-flags to the GT.
- train_done, output, 1, sticky flag: training burst complete.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - gt_txdata=ALIGN_WORD, gt_txcharisk=4'b0001, s_ready=0, train_done=0.
  - state=TRAIN; train_cnt, period_cnt and burst_cnt all =0.
- Outputs are registered. On each edge the block loads the word for the next cycle. Latency from an accepted input to gt_txdata is 1 clock.
- Handshake:
  - s_ready is combinational: s_ready = (state==RUN) && (period_cnt != ALIGN_PERIOD-1).
  - A transfer occurs on an edge where s_ready=1 and s_valid=1.
  - s_ready does not depend on s_valid.
- State TRAIN:
  - Each edge loads ALIGN_WORD / 4'b0001 and increments train_cnt.
  - On the edge where train_cnt==TRAIN_LEN-1: state goes to RUN and train_done is set to 1 on that same edge.
- State RUN, period_cnt != ALIGN_PERIOD-1:
  - If s_valid=1: load s_data / s_charisk.
  - If s_valid=0: load IDLE_WORD / 4'b0001.
  - period_cnt is incremented in both cases.
- State RUN, period_cnt == ALIGN_PERIOD-1:
  - Load ALIGN_WORD / 4'b0001; period_cnt:=0.
  - If ALIGN_BURST==1, stay in RUN. Otherwise go to ALIGN with burst_cnt:=1.
- State ALIGN:
  - Each edge loads ALIGN_WORD / 4'b0001 and increments burst_cnt.
  - On the edge where burst_cnt==ALIGN_BURST-1: burst_cnt:=0, state goes to RUN.
  - period_cnt is frozen at 0.
- Steady-state cycle length is ALIGN_PERIOD-1+ALIGN_BURST words, with exactly ALIGN_BURST consecutive alignment words per cycle.
- An upstream word that is held with s_valid=1 while s_ready=0 is neither lost nor duplicated. It is transferred on the first edge with s_ready=1.
- train_done stays 1 until the next rst. There is no retraining without rst.
- Counter widths use $clog2 of the relevant parameter. No wrap occurs other than the defined reloads.
- Reset mid-operation (any state): outputs return to their reset values immediately. A word accepted on the last edge before reset is dropped. Training restarts from train_cnt=0.
- No state is reachable other than TRAIN, RUN and ALIGN. An illegal encoding recovers to TRAIN.

Test Plan:
- Reset release, s_valid=1, defaults:
  - gt_txdata=32'h55a100bc with charisk 4'b0001 through edge 64.
  - s_ready first high after edge 64; train_done=1 after edge 64.
  - The first upstream word appears after edge 65.
- Continuous s_valid=1, incrementing s_data from 0:
  - 255 data words 0..254 with charisk passed through.
  - Then 4 ALIGN_WORDs, with s_ready=0 during the 4 decision cycles.
  - Next data word is 255, with no gap or duplicate.
- s_valid=0 in RUN: gt_txdata=32'h55a109bc, charisk 4'b0001. Alignment bursts are still inserted every 259 cycles.
- ALIGN_BURST=1, ALIGN_PERIOD=2: output alternates data/ALIGN_WORD, and s_ready toggles every cycle.
- s_valid held with s_data=32'hdeadbeef across an alignment burst: the word appears exactly once, right after the 4th ALIGN_WORD.
- rst pulsed mid-RUN: outputs immediately show ALIGN_WORD, 4'b0001, s_ready=0, train_done=0. The full 64-word training burst repeats.

Source files
------------

// File: rtl/sfp_tx_align_gen.sv
// TX-side alignment generator for the SFP 8b/10b link: emits a comma training burst after
// reset, then forwards upstream words with periodic alignment bursts and UNUSE idle fill.
module sfp_tx_align_gen #(
    parameter int          TRAIN_LEN    = 64,
    parameter int          ALIGN_PERIOD = 256,
    parameter int          ALIGN_BURST  = 4,
    parameter logic [31:0] ALIGN_WORD   = 32'h55a100bc,
    parameter logic [31:0] IDLE_WORD    = 32'h55a109bc
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_data,
    input  logic [3:0]  s_charisk,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [31:0] gt_txdata,
    output logic [3:0]  gt_txcharisk,
    output logic        train_done
);

    localparam int TW = (TRAIN_LEN > 1) ? $clog2(TRAIN_LEN) : 1;
    localparam int PW = $clog2(ALIGN_PERIOD);
    localparam int BW = (ALIGN_BURST > 1) ? $clog2(ALIGN_BURST) : 1;

    localparam logic [TW-1:0] TRAIN_LAST  = TW'(TRAIN_LEN - 1);
    localparam logic [PW-1:0] PERIOD_LAST = PW'(ALIGN_PERIOD - 1);
    localparam logic [BW-1:0] BURST_LAST  = BW'(ALIGN_BURST - 1);

    typedef enum logic [1:0] {
        ST_TRAIN = 2'd0,
        ST_RUN   = 2'd1,
        ST_ALIGN = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] train_cnt_q, train_cnt_d;
    logic [PW-1:0] period_cnt_q, period_cnt_d;
    logic [BW-1:0] burst_cnt_q, burst_cnt_d;
    logic [31:0]   gt_txdata_q, gt_txdata_d;
    logic [3:0]    gt_txcharisk_q, gt_txcharisk_d;
    logic          train_done_q, train_done_d;

    // The last slot of each period is the decision slot that starts the alignment burst.
    assign s_ready      = (state_q == ST_RUN) && (period_cnt_q != PERIOD_LAST);
    assign gt_txdata    = gt_txdata_q;
    assign gt_txcharisk = gt_txcharisk_q;
    assign train_done   = train_done_q;

    always_comb begin
        state_d        = state_q;
        train_cnt_d    = train_cnt_q;
        period_cnt_d   = period_cnt_q;
        burst_cnt_d    = burst_cnt_q;
        train_done_d   = train_done_q;
        gt_txdata_d    = ALIGN_WORD;
        gt_txcharisk_d = 4'b0001;

        case (state_q)
            ST_TRAIN: begin
                if (train_cnt_q == TRAIN_LAST) begin
                    state_d      = ST_RUN;
                    train_done_d = 1'b1;
                end else begin
                    train_cnt_d = train_cnt_q + TW'(1);
                end
            end
            ST_RUN: begin
                if (period_cnt_q != PERIOD_LAST) begin
                    if (s_valid) begin
                        gt_txdata_d    = s_data;
                        gt_txcharisk_d = s_charisk;
                    end else begin
                        gt_txdata_d = IDLE_WORD;
                    end
                    period_cnt_d = period_cnt_q + PW'(1);
                end else begin
                    period_cnt_d = '0;
                    if (ALIGN_BURST > 1) begin
                        state_d     = ST_ALIGN;
                        burst_cnt_d = BW'(1);
                    end
                end
            end
            ST_ALIGN: begin
                period_cnt_d = '0;
                if (burst_cnt_q == BURST_LAST) begin
                    burst_cnt_d = '0;
                    state_d     = ST_RUN;
                end else begin
                    burst_cnt_d = burst_cnt_q + BW'(1);
                end
            end
            default: begin
                state_d      = ST_TRAIN;
                train_cnt_d  = '0;
                period_cnt_d = '0;
                burst_cnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_TRAIN;
            train_cnt_q    <= '0;
            period_cnt_q   <= '0;
            burst_cnt_q    <= '0;
            gt_txdata_q    <= ALIGN_WORD;
            gt_txcharisk_q <= 4'b0001;
            train_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            train_cnt_q    <= train_cnt_d;
            period_cnt_q   <= period_cnt_d;
            burst_cnt_q    <= burst_cnt_d;
            gt_txdata_q    <= gt_txdata_d;
            gt_txcharisk_q <= gt_txcharisk_d;
            train_done_q   <= train_done_d;
        end
    end

endmodule

// File: tb/tb_sfp_tx_align_gen.sv
// Scoreboard bench for sfp_tx_align_gen: default instance plus a short-period, single-word-burst
// instance; expected words are queued by the stimulus and compared by an independent monitor.
module tb_sfp_tx_align_gen;

    localparam logic [31:0] ALIGN = 32'h55a100bc;
    localparam logic [31:0] IDLE  = 32'h55a109bc;

    logic        clk;
    logic        rst;
    logic [31:0] sData,  s2Data;
    logic [3:0]  sCharisk, s2Charisk;
    logic        sValid, s2Valid;
    logic        sReady, s2Ready;
    logic [31:0] txData, tx2Data;
    logic [3:0]  txCharisk, tx2Charisk;
    logic        trainDone, train2Done;

    typedef struct {
        bit          sel;
        logic [31:0] data;
        logic [3:0]  k;
        logic        ready;
        logic        done;
    } expT;

    expT expQ[$];
    int  checks = 0;
    int  errors = 0;

    sfp_tx_align_gen dut (
        .clk          (clk),
        .rst          (rst),
        .s_data       (sData),
        .s_charisk    (sCharisk),
        .s_valid      (sValid),
        .s_ready      (sReady),
        .gt_txdata    (txData),
        .gt_txcharisk (txCharisk),
        .train_done   (trainDone)
    );

    sfp_tx_align_gen #(
        .TRAIN_LEN    (2),
        .ALIGN_PERIOD (2),
        .ALIGN_BURST  (1)
    ) dut2 (
        .clk          (clk),
        .rst          (rst),
        .s_data       (s2Data),
        .s_charisk    (s2Charisk),
        .s_valid      (s2Valid),
        .s_ready      (s2Ready),
        .gt_txdata    (tx2Data),
        .gt_txcharisk (tx2Charisk),
        .train_done   (train2Done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s (check %0d): got %h, expected %h", name, checks, act, exp);
        end
    endtask

    // Called at a negedge: drive one cycle of input, queue what must appear after the next edge.
    task automatic applyStimulus(input bit sel, input logic v, input logic [31:0] d,
                                 input logic [3:0] k, input logic [31:0] ed,
                                 input logic [3:0] ek, input logic er, input logic edn);
        expT e;
        if (sel == 1'b0) begin
            sValid   = v;
            sData    = d;
            sCharisk = k;
            s2Valid  = 1'b0;
        end else begin
            s2Valid   = v;
            s2Data    = d;
            s2Charisk = k;
            sValid    = 1'b0;
        end
        e.sel   = sel;
        e.data  = ed;
        e.k     = ek;
        e.ready = er;
        e.done  = edn;
        expQ.push_back(e);
        @(negedge clk);
    endtask

    initial begin : monitor
        expT e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                if (e.sel == 1'b0) begin
                    checkOutput("dut1 gt_txdata", txData, e.data);
                    checkOutput("dut1 gt_txcharisk", 32'(txCharisk), 32'(e.k));
                    checkOutput("dut1 s_ready", 32'(sReady), 32'(e.ready));
                    checkOutput("dut1 train_done", 32'(trainDone), 32'(e.done));
                end else begin
                    checkOutput("dut2 gt_txdata", tx2Data, e.data);
                    checkOutput("dut2 gt_txcharisk", 32'(tx2Charisk), 32'(e.k));
                    checkOutput("dut2 s_ready", 32'(s2Ready), 32'(e.ready));
                    checkOutput("dut2 train_done", 32'(train2Done), 32'(e.done));
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkResetState(input string tag);
        checkOutput({tag, " reset gt_txdata"}, txData, ALIGN);
        checkOutput({tag, " reset gt_txcharisk"}, 32'(txCharisk), 32'd1);
        checkOutput({tag, " reset s_ready"}, 32'(sReady), 32'd0);
        checkOutput({tag, " reset train_done"}, 32'(trainDone), 32'd0);
        checkOutput({tag, " reset dut2 gt_txdata"}, tx2Data, ALIGN);
        checkOutput({tag, " reset dut2 s_ready"}, 32'(s2Ready), 32'd0);
        checkOutput({tag, " reset dut2 train_done"}, 32'(train2Done), 32'd0);
    endtask

    initial begin : stimulus
        rst       = 1'b1;
        sData     = '0;
        sCharisk  = '0;
        sValid    = 1'b1;
        s2Data    = '0;
        s2Charisk = '0;
        s2Valid   = 1'b0;
        #1;
        checkResetState("initial");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int e = 1; e <= 64; e++)
            applyStimulus(0, 1, 32'h0, 4'h0, ALIGN, 4'b0001, e == 64, e == 64);
        for (int i = 0; i < 255; i++)
            applyStimulus(0, 1, 32'(i), 4'(i), 32'(i), 4'(i), i != 254, 1);
        for (int i = 0; i < 4; i++)
            applyStimulus(0, 1, 32'd255, 4'hf, ALIGN, 4'b0001, i == 3, 1);
        for (int i = 255; i < 510; i++)
            applyStimulus(0, 1, 32'(i), 4'(i), 32'(i), 4'(i), i != 509, 1);

        // deadbeef is offered during the whole burst and must land once, right after it
        for (int i = 0; i < 4; i++)
            applyStimulus(0, 1, 32'hdeadbeef, 4'b1010, ALIGN, 4'b0001, i == 3, 1);
        applyStimulus(0, 1, 32'hdeadbeef, 4'b1010, 32'hdeadbeef, 4'b1010, 1, 1);

        for (int i = 1; i < 255; i++)
            applyStimulus(0, 0, 32'h12345678, 4'hf, IDLE, 4'b0001, i != 254, 1);
        for (int i = 0; i < 4; i++)
            applyStimulus(0, 0, 32'h12345678, 4'hf, ALIGN, 4'b0001, i == 3, 1);
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 0, 32'h12345678, 4'hf, IDLE, 4'b0001, 1, 1);

        #2;
        rst = 1'b1;
        #1;
        checkResetState("mid-run");
        @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= 64; e++)
            applyStimulus(0, 1, 32'hcafef00d, 4'h3, ALIGN, 4'b0001, e == 64, e == 64);
        applyStimulus(0, 1, 32'hcafef00d, 4'h3, 32'hcafef00d, 4'h3, 1, 1);
        applyStimulus(0, 1, 32'h0badf00d, 4'h0, 32'h0badf00d, 4'h0, 1, 1);

        #2;
        rst = 1'b1;
        #1;
        checkResetState("pre-dut2");
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1, 1, 32'h000000a0, 4'h0, ALIGN, 4'b0001, 0, 0);
        applyStimulus(1, 1, 32'h000000a0, 4'h0, ALIGN, 4'b0001, 1, 1);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 1, 32'(32'ha0 + i), 4'(i), 32'(32'ha0 + i), 4'(i), 0, 1);
            applyStimulus(1, 1, 32'(32'ha0 + i + 1), 4'(i + 1), ALIGN, 4'b0001, 1, 1);
        end

        repeat (2) @(negedge clk);
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
